// File: rtl/acq_sequencer_if.sv
// Signal bundle between the acquisition sequencer and its environment:
// run control/status, PMT capture events, the single bin-RAM port and the
// drain stream. The sequencer uses the slave modport; whatever surrounds it
// (gating logic, RAM, readout) uses the master modport.
interface acq_sequencer_if #(
   parameter int ADDR_WIDTH  = 7,
   parameter int BIN_WIDTH   = 32,
   parameter int TIMER_WIDTH = 64,
   parameter int DROP_WIDTH  = 16
);
   logic                   start;
   logic                   abort;
   logic [TIMER_WIDTH-1:0] integration_cycles;
   logic                   capture_req;
   logic [ADDR_WIDTH-1:0]  capture_bin;
   logic [ADDR_WIDTH-1:0]  ram_addr;
   logic                   ram_we;
   logic [BIN_WIDTH-1:0]   ram_wdata;
   logic [BIN_WIDTH-1:0]   ram_rdata;
   logic                   out_valid;
   logic                   out_ready;
   logic [BIN_WIDTH-1:0]   out_data;
   logic                   out_last;
   logic                   busy;
   logic                   done;
   logic [DROP_WIDTH-1:0]  dropped_count;

   modport slave (
      input  start, abort, integration_cycles, capture_req, capture_bin,
             ram_rdata, out_ready,
      output ram_addr, ram_we, ram_wdata, out_valid, out_data, out_last,
             busy, done, dropped_count
   );

   modport master (
      output start, abort, integration_cycles, capture_req, capture_bin,
             ram_rdata, out_ready,
      input  ram_addr, ram_we, ram_wdata, out_valid, out_data, out_last,
             busy, done, dropped_count
   );
endinterface

// File: rtl/acq_sequencer.sv
// Photon-counting acquisition run sequencer: clears the histogram bins,
// integrates PMT capture events into them with read-modify-write, then drains
// them as a valid/ready stream. Owns the only port of the bin RAM (read data
// returns one cycle after the address).
// Build option: define ACQ_SATURATE_EN to make bins stick at all-ones instead
// of wrapping.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | waiting for start; dropped_count holds last run's value
// ST_CLEAR     | writes 0 to bins 0..NUM_BINS-1, one per cycle
// ST_INTEGRATE | timer running; capture events RMW their bin (2 cycles)
// ST_DRAIN_RD  | presents the drain index to the RAM
// ST_DRAIN_OUT | offers the bin value on the stream until accepted
// ST_DONE      | one-cycle done pulse
module acq_sequencer #(
   parameter int NUM_BINS    = 100,
   parameter int ADDR_WIDTH  = 7,
   parameter int BIN_WIDTH   = 32,
   parameter int TIMER_WIDTH = 64,
   parameter int DROP_WIDTH  = 16
) (
   input logic             main_clock,
   input logic             reset,
   acq_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {
      ST_IDLE, ST_CLEAR, ST_INTEGRATE, ST_DRAIN_RD, ST_DRAIN_OUT, ST_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  index_q;
   logic [TIMER_WIDTH-1:0] timer_q;
   logic [TIMER_WIDTH-1:0] len_q;
   logic                   rmw_pend_q;
   logic [ADDR_WIDTH-1:0]  rmw_addr_q;
   logic [DROP_WIDTH-1:0]  drop_q;
   logic [BIN_WIDTH-1:0]   data_q;
   logic                   held_q;

   logic                   terminal;
   logic                   abort_hit;
   logic                   rmw_take;
   logic                   drop_evt;
   logic [BIN_WIDTH-1:0]   bin_inc;

   assign terminal  = (timer_q == len_q - TIMER_WIDTH'(1));
   assign abort_hit = bus.abort && (state_q != ST_IDLE);
   assign bus.dropped_count = drop_q;

`ifdef ACQ_SATURATE_EN
   assign bin_inc = (&bus.ram_rdata) ? bus.ram_rdata : bus.ram_rdata + BIN_WIDTH'(1);
`else
   assign bin_inc = bus.ram_rdata + BIN_WIDTH'(1);
`endif

   // Next state, RAM port arbitration and stream outputs.
   always_comb begin
      state_d       = state_q;
      bus.ram_addr  = '0;
      bus.ram_we    = 1'b0;
      bus.ram_wdata = '0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.busy      = (state_q != ST_IDLE);
      bus.done      = 1'b0;
      rmw_take      = 1'b0;
      drop_evt      = 1'b0;
      // first DRAIN_OUT cycle passes the RAM data straight through; it is
      // held in data_q from then on so a stalled beat cannot change
      bus.out_data  = (state_q == ST_DRAIN_OUT && !held_q) ? bus.ram_rdata : data_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            bus.ram_we   = 1'b1;
            bus.ram_addr = index_q;
            if (index_q == LAST_BIN) state_d = ST_INTEGRATE;
         end
         ST_INTEGRATE: begin
            if (rmw_pend_q) begin
               // write half of an RMW owns the port; a new event is lost
               bus.ram_addr  = rmw_addr_q;
               bus.ram_we    = 1'b1;
               bus.ram_wdata = bin_inc;
               drop_evt      = bus.capture_req;
            end else if (bus.capture_req) begin
               if (bus.capture_bin > LAST_BIN || terminal) begin
                  drop_evt = 1'b1;
               end else begin
                  bus.ram_addr = bus.capture_bin;
                  rmw_take     = 1'b1;
               end
            end
            if (terminal) state_d = ST_DRAIN_RD;
         end
         ST_DRAIN_RD: begin
            bus.ram_addr = index_q;
            state_d      = ST_DRAIN_OUT;
         end
         ST_DRAIN_OUT: begin
            bus.ram_addr  = index_q;
            bus.out_valid = 1'b1;
            bus.out_last  = (index_q == LAST_BIN);
            if (bus.out_ready) state_d = (index_q == LAST_BIN) ? ST_DONE : ST_DRAIN_RD;
         end
         ST_DONE: begin
            bus.done = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort_hit) state_d = ST_IDLE;
   end

   // State register plus index, timer, RMW and drop bookkeeping.
   always_ff @(posedge main_clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         index_q    <= '0;
         timer_q    <= '0;
         len_q      <= '0;
         rmw_pend_q <= 1'b0;
         rmw_addr_q <= '0;
         drop_q     <= '0;
         data_q     <= '0;
         held_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (state_d == ST_CLEAR) begin
                  len_q   <= (bus.integration_cycles == '0) ? TIMER_WIDTH'(1)
                                                            : bus.integration_cycles;
                  drop_q  <= '0;
                  index_q <= '0;
               end
            end
            ST_CLEAR: begin
               index_q <= (index_q == LAST_BIN) ? '0 : index_q + ADDR_WIDTH'(1);
               timer_q <= '0;
            end
            ST_INTEGRATE: begin
               timer_q    <= timer_q + TIMER_WIDTH'(1);
               rmw_pend_q <= rmw_take;
               if (rmw_take) rmw_addr_q <= bus.capture_bin;
               if (drop_evt && !(&drop_q)) drop_q <= drop_q + DROP_WIDTH'(1);
            end
            ST_DRAIN_RD: begin
               held_q <= 1'b0;
            end
            ST_DRAIN_OUT: begin
               if (!held_q) begin
                  data_q <= bus.ram_rdata;
                  held_q <= 1'b1;
               end
               if (bus.out_ready && index_q != LAST_BIN) index_q <= index_q + ADDR_WIDTH'(1);
            end
            default: ;
         endcase
         if (abort_hit) begin
            rmw_pend_q <= 1'b0;
            held_q     <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: drives runs (directed and random capture
// schedules), models the bin RAM, and checks the drain stream against a
// histogram computed from the capture schedule.
module tb_acq_sequencer;
   localparam int NB = 100;
   localparam int AW = 7;
   localparam int BW = 4;
   localparam int TW = 64;
   localparam int DW = 16;

   logic main_clock = 1'b0;
   logic reset      = 1'b1;
   always #5 main_clock = ~main_clock;

   acq_sequencer_if #(.ADDR_WIDTH(AW), .BIN_WIDTH(BW), .TIMER_WIDTH(TW), .DROP_WIDTH(DW)) bus();

   acq_sequencer #(.NUM_BINS(NB), .ADDR_WIDTH(AW), .BIN_WIDTH(BW),
                   .TIMER_WIDTH(TW), .DROP_WIDTH(DW)) dut (
      .main_clock (main_clock),
      .reset      (reset),
      .bus        (bus)
   );

   // single-port RAM, read data one cycle after address, random power-up
   logic [BW-1:0] mem [0:(2**AW)-1];
   bit mem_init_done = 1'b0;
   always @(posedge main_clock) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= BW'($urandom);
         mem_init_done <= 1'b1;
      end else begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         bus.ram_rdata <= mem[bus.ram_addr];
      end
   end

   typedef struct packed { logic last; logic [BW-1:0] data; } word_t;
   word_t sb[$];

   int checks = 0;
   int errors = 0;
   int hs_count = 0;
   bit expect_done = 1'b0;
   bit stall_prev = 1'b0;
   logic [BW-1:0] stall_data;
   logic stall_last;

   bit            sreq [512];
   logic [AW-1:0] sbin [512];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge main_clock);
      #1;
   endtask

   // monitor: scoreboard pops on handshakes, stall stability, done timing
   always @(negedge main_clock) begin
      word_t w;
      if (reset) begin
         stall_prev  = 1'b0;
         expect_done = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", 64'(bus.out_valid), 64'(1));
            check("stall_data", 64'(bus.out_data), 64'(stall_data));
            check("stall_last", 64'(bus.out_last), 64'(stall_last));
         end
         stall_prev = bus.out_valid && !bus.out_ready && !bus.abort;
         stall_data = bus.out_data;
         stall_last = bus.out_last;
         if (bus.done || expect_done) check("done_pulse", 64'(bus.done), 64'(expect_done));
         expect_done = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_word", 64'(1), 64'(0));
            end else begin
               w = sb.pop_front();
               check($sformatf("word%0d_data", hs_count), 64'(bus.out_data), 64'(w.data));
               check($sformatf("word%0d_last", hs_count), 64'(bus.out_last), 64'(w.last));
               expect_done = w.last;
            end
            hs_count++;
         end
      end
   end

   function automatic int bump(input int v);
`ifdef ACQ_SATURATE_EN
      return (v == 2**BW - 1) ? v : v + 1;
`else
      return (v + 1) % (2**BW);
`endif
   endfunction

   task automatic clear_sched();
      for (int k = 0; k < 512; k++) begin
         sreq[k] = 1'b0;
         sbin[k] = '0;
      end
   endtask

   task automatic random_sched(input int len, input int pct);
      clear_sched();
      for (int k = 0; k < len; k++) begin
         sreq[k] = ($urandom_range(0, 99) < pct);
         sbin[k] = AW'($urandom_range(0, 2**AW - 1));
      end
   endtask

   task automatic run(input longint len, input int reset_at, input bit stall10, input bit abort50);
      int    leff;
      int    model [NB];
      int    drops;
      int    n;
      int    stall_left;
      bit    prev_acc;
      bit    acc;
      bit    stalled;
      leff = (len == 0) ? 1 : int'(len);

      // reference: histogram and drop count straight from the capture rules
      for (int b = 0; b < NB; b++) model[b] = 0;
      drops    = 0;
      prev_acc = 1'b0;
      for (int k = 0; k < leff; k++) begin
         acc = 1'b0;
         if (sreq[k]) begin
            if (prev_acc || int'(sbin[k]) >= NB || k == leff - 1) begin
               if (drops < 2**DW - 1) drops++;
            end else begin
               acc = 1'b1;
               model[sbin[k]] = bump(model[sbin[k]]);
            end
         end
         prev_acc = acc;
      end

      bus.start = 1'b1;
      bus.integration_cycles = len;
      tick();
      bus.start = 1'b0;
      hs_count  = 0;
      check("run_busy", 64'(bus.busy), 64'(1));
      for (int i = 0; i < NB; i++) begin
         check($sformatf("clear%0d", i), 64'({bus.ram_we, bus.ram_addr, bus.ram_wdata}),
               64'({1'b1, AW'(i), BW'(0)}));
         tick();
      end
      for (int k = 0; k < leff; k++) begin
         bus.capture_req = sreq[k];
         bus.capture_bin = sbin[k];
         if (k == reset_at) begin
            #2 reset = 1'b1;
            #1;
            check("reset_outputs", 64'({bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.out_valid,
                  bus.out_data, bus.out_last, bus.done, bus.dropped_count}), 64'(0));
            check("reset_busy", 64'(bus.busy), 64'(0));
            bus.capture_req = 1'b0;
            #2 reset = 1'b0;
            return;
         end
         tick();
      end
      bus.capture_req = 1'b0;
      for (int b = 0; b < NB; b++) sb.push_back('{last: (b == NB - 1), data: BW'(model[b])});

      n = 0;
      stall_left = 0;
      stalled = 1'b0;
      while (!bus.done && n < 3000) begin
         bus.capture_req = 1'($urandom_range(0, 1));
         bus.capture_bin = AW'($urandom_range(0, 2**AW - 1));
         if (abort50 && bus.out_valid && hs_count == 50) begin
            bus.abort = 1'b1;
            bus.start = 1'b1;
            bus.out_ready = 1'b0;
            tick();
            bus.abort = 1'b0;
            bus.start = 1'b0;
            bus.capture_req = 1'b0;
            check("abort_valid", 64'(bus.out_valid), 64'(0));
            check("abort_busy", 64'(bus.busy), 64'(0));
            check("abort_we", 64'(bus.ram_we), 64'(0));
            repeat (3) begin
               tick();
               check("abort_start_ignored", 64'(bus.busy), 64'(0));
            end
            sb.delete();
            return;
         end
         if (stall10 && !stalled && bus.out_valid && hs_count == 10) begin
            stall_left = 5;
            stalled = 1'b1;
         end
         if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
         end else begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
         end
         tick();
         n++;
      end
      bus.capture_req = 1'b0;
      bus.out_ready = 1'b0;
      check("drain_timeout", 64'(n < 3000), 64'(1));
      check("done_busy", 64'(bus.busy), 64'(1));
      check("word_count", 64'(hs_count), 64'(NB));
      check("sb_left", 64'(sb.size()), 64'(0));
      check("dropped", 64'(bus.dropped_count), 64'(drops));
      tick();
      check("idle_busy", 64'(bus.busy), 64'(0));
      check("idle_done", 64'(bus.done), 64'(0));
      check("dropped_hold", 64'(bus.dropped_count), 64'(drops));
      sb.delete();
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.integration_cycles = '0;
      bus.capture_req = 1'b0;
      bus.capture_bin = '0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      check("por_outputs", 64'({bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.out_valid,
            bus.out_data, bus.out_last, bus.busy, bus.done, bus.dropped_count}), 64'(0));
      reset = 1'b0;
      tick();
      check("post_reset_busy", 64'(bus.busy), 64'(0));

      // bin 3 three times; terminal-cycle event on bin 5 is dropped
      clear_sched();
      sreq[2] = 1; sbin[2] = 3;
      sreq[5] = 1; sbin[5] = 3;
      sreq[8] = 1; sbin[8] = 3;
      sreq[19] = 1; sbin[19] = 5;
      run(20, -1, 1'b0, 1'b0);

      // back-to-back on bin 7 and an out-of-range bin, with a stall at bin 10
      clear_sched();
      sreq[4] = 1; sbin[4] = 7;
      sreq[5] = 1; sbin[5] = 7;
      sreq[10] = 1; sbin[10] = 120;
      run(30, -1, 1'b1, 1'b0);

      // 20 spaced events on bin 0 overflow a 4-bit bin
      clear_sched();
      for (int p = 0; p < 20; p++) begin
         sreq[p*3] = 1;
         sbin[p*3] = 0;
      end
      run(70, -1, 1'b0, 1'b0);

      // reset in the middle of integration, then a full run from scratch
      random_sched(50, 50);
      run(50, 25, 1'b0, 1'b0);
      tick();
      check("after_reset_dropped", 64'(bus.dropped_count), 64'(0));
      random_sched(40, 40);
      run(40, -1, 1'b0, 1'b0);

      // abort in drain at bin 50 with a simultaneous start
      random_sched(10, 50);
      run(10, -1, 1'b0, 1'b1);

      // integration length 0 behaves as 1; length 1 is all terminal
      clear_sched();
      sreq[0] = 1; sbin[0] = 9;
      run(0, -1, 1'b0, 1'b0);
      run(1, -1, 1'b0, 1'b0);

      // event just before the terminal cycle completes its write there
      clear_sched();
      sreq[13] = 1; sbin[13] = 99;
      run(15, -1, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         int len;
         len = $urandom_range(2, 200);
         random_sched(len, $urandom_range(20, 80));
         run(longint'(len), -1, 1'(r % 2), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Sequences one photon-counting acquisition run: clear histogram bins, integrate PMT capture events into them, then drain them as a stream. Owns the only port of the single-port bin RAM and arbitrates it between clear, capture read-modify-write (RMW) and drain. Sits between the PMT capture/gating logic (source of capture_req/capture_bin) and the readout path (stream sink).

Parameters:
NUM_BINS, 100, number of histogram bins
ADDR_WIDTH, 7, bin RAM address width; 2**ADDR_WIDTH >= NUM_BINS
BIN_WIDTH, 32, bin counter width
TIMER_WIDTH, 64, integration timer width
DROP_WIDTH, 16, dropped-event counter width

Ports:
main_clock  in  1  the single clock
reset  in  1  asynchronous, active-high
start  in  1  one-cycle run request; ignored unless state IDLE
abort  in  1  level; forces return to IDLE
integration_cycles  in  TIMER_WIDTH  length of INTEGRATE in clocks; sampled on accepted start
capture_req  in  1  one-cycle pulse per gated PMT event
capture_bin  in  ADDR_WIDTH  bin index for capture_req
ram_addr  out  ADDR_WIDTH  bin RAM address
ram_we  out  1  bin RAM write enable
ram_wdata  out  BIN_WIDTH  bin RAM write data
ram_rdata  in  BIN_WIDTH  bin RAM read data, valid one cycle after ram_addr
out_valid  out  1  drain stream valid
out_ready  in  1  drain stream ready
out_data  out  BIN_WIDTH  bin value
out_last  out  1  high with bin NUM_BINS-1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at run completion
dropped_count  out  DROP_WIDTH  events dropped in current run, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0.
- States: IDLE, CLEAR, INTEGRATE, DRAIN_RD, DRAIN_OUT, DONE.
- IDLE -> CLEAR on start; latch integration_cycles (0 treated as 1); dropped_count <= 0.
- CLEAR: ram_we=1, ram_wdata=0, ram_addr 0..NUM_BINS-1, one per cycle; after last address -> INTEGRATE with timer=0.
- INTEGRATE: timer increments each cycle. RMW: accept cycle drives ram_addr=capture_bin, ram_we=0; next cycle ram_we=1, ram_wdata=ram_rdata+1, same address. Port busy two cycles.
- capture_req dropped (dropped_count+1, saturating at all-ones) if: RMW write cycle in progress, capture_bin >= NUM_BINS, or timer == integration_cycles-1 (terminal cycle).
- capture_req outside INTEGRATE: ignored, not counted.
- Terminal cycle: if RMW write pending, it completes first; then -> DRAIN_RD with index 0.
- DRAIN_RD: ram_addr=index, ram_we=0; -> DRAIN_OUT.
- DRAIN_OUT: out_data registered from ram_rdata on entry; out_valid=1, out_last=(index==NUM_BINS-1); out_data/out_last stable while out_ready=0. On handshake: last -> DONE, else index+1 -> DRAIN_RD. Minimum 2 cycles per bin.
- DONE: done=1 one cycle -> IDLE.
- abort (any non-IDLE state): next cycle IDLE, out_valid=0, ram_we=0, in-flight RMW discarded; bin contents undefined, next start clears them. abort has priority over start in the same cycle.
- dropped_count holds its value in IDLE until next accepted start.

Optional Feature:
ACQ_SATURATE_EN: defined -> RMW writes ram_rdata unchanged when ram_rdata is all-ones (bin saturates); not defined -> bin wraps modulo 2**BIN_WIDTH.

Test Plan:
- Reset asserted mid-INTEGRATE -> all outputs 0 immediately, busy=0; next start performs full CLEAR (NUM_BINS cycles of ram_we=1, wdata=0).
- start, integration_cycles=20, capture_req bin 3 at cycles 2,5,8 -> drain emits 100 words, bin 3 =3, others 0, out_last only on word 99, done one cycle after last handshake.
- capture_req on two consecutive cycles (bin 7) -> bin 7 =1, dropped_count=1; capture_bin=120 -> dropped_count=2.
- out_ready low for 5 cycles during bin 10 -> out_valid held, out_data unchanged, no index advance.
- BIN_WIDTH=4, 20 spaced pulses to bin 0 -> bin 0 =15 with ACQ_SATURATE_EN, =4 without.
- abort during DRAIN_OUT at bin 50 -> out_valid 0 next cycle, busy 0, no done pulse; start in same cycle as abort ignored.
